// File: rtl/inc_counter_bank_pkg.sv
// Shared helpers for the counter bank: rightmost-zero incrementer pieces and
// the round-robin picker. Widths are fixed maxima; callers extend/truncate.
package inc_pkg;

  localparam int MAX_W = 64;
  localparam int MAX_N = 16;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_N-1:0] req_vec_t;
  typedef logic [3:0]       ptr_t;

  // One-hot of the lowest zero bit; zero when x is all-ones.
  function automatic word_t ffs0(input word_t x);
    word_t oh;
    logic  found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (!found && !x[i]) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  // Sets every bit at and below the one-hot position; all-ones for oh == 0.
  function automatic word_t inclusive_mask(input word_t oh);
    word_t m;
    logic  run;
    m   = '0;
    run = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      run  = run | oh[i];
      m[i] = run;
    end
    if (oh == '0) m = '1;
    return m;
  endfunction

  // First set bit of v at or after ptr, wrapping modulo n; one-hot result.
  function automatic req_vec_t rr_pick(input req_vec_t v, input ptr_t ptr, input int n);
    req_vec_t pick;
    logic     found;
    ptr_t     idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = ptr_t'((int'(ptr) + k) % n);
      if (k < n && !found && v[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/inc_counter_bank_fast_inc.sv
// Adder-free incrementer: flip the run of trailing ones plus the first zero.
// Works for W up to inc_pkg::MAX_W; the zero-extended top bit absorbs the wrap.
module fast_inc
  import inc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         wrap
);

  typedef logic [W-1:0] cnt_t;

  word_t x_ext;
  word_t res;

  always_comb begin
    x_ext = word_t'(x);
    res   = x_ext ^ inclusive_mask(ffs0(x_ext));
  end

  assign y    = cnt_t'(res);
  assign wrap = &x;

endmodule

// File: rtl/inc_counter_bank.sv
// Bank of N counters sharing one incrementer; a round-robin arbiter grants one
// increment per cycle and a registered response reports the new value.
module inc_counter_bank
  import inc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         ack,
  input  logic                 clr_vld,
  input  logic [$clog2(N)-1:0] clr_id,
  output logic                 rsp_vld,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_cnt,
  output logic                 rsp_wrap,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef logic [N-1:0]  vec_t;
  typedef logic [IW-1:0] id_t;

  logic [W-1:0] cnt [N];
  id_t          rr_ptr;
  id_t          gnt_id;
  vec_t         elig;
  vec_t         pick;
  logic         gnt;
  logic [W-1:0] inc_val;
  logic         inc_wrap;

  // A counter being cleared this cycle cannot also be incremented.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++)
      elig[i] = req[i] & ~(clr_vld & (clr_id == id_t'(i)));
  end

  assign pick = vec_t'(rr_pick(req_vec_t'(elig), ptr_t'(rr_ptr), N));
  assign ack  = rst ? '0 : pick;
  assign gnt  = |ack;
  assign busy = |req;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N; i++)
      if (pick[i]) gnt_id = id_t'(i);
  end

  fast_inc #(.W(W)) u_inc (
    .x    (cnt[gnt_id]),
    .y    (inc_val),
    .wrap (inc_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_vld && clr_id == id_t'(i)) cnt[i] <= '0;
        else if (ack[i])                   cnt[i] <= inc_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_cnt  <= '0;
      rsp_wrap <= 1'b0;
    end else if (gnt) begin
      rr_ptr   <= (gnt_id == id_t'(N - 1)) ? '0 : gnt_id + id_t'(1);
      rsp_vld  <= 1'b1;
      rsp_id   <= gnt_id;
      rsp_cnt  <= inc_val;
      rsp_wrap <= inc_wrap;
    end else begin
      rsp_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inc_counter_bank.sv
// Bench for inc_counter_bank: directed scenarios plus random traffic compared
// every cycle against a +1-arithmetic behavioural model.
module tb_inc_counter_bank;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         clr_vld = 1'b0;
  logic [1:0]   clr_id = '0;
  logic [N-1:0] ack;
  logic         rsp_vld;
  logic [1:0]   rsp_id;
  logic [W-1:0] rsp_cnt;
  logic         rsp_wrap;
  logic         busy;

  logic [N-1:0]  req_s = '0;
  logic          clr_vld_s = 1'b0;
  logic [1:0]    clr_id_s = '0;
  logic [N-1:0]  ack_s;
  logic          rsp_vld_s;
  logic [1:0]    rsp_id_s;
  logic [SW-1:0] rsp_cnt_s;
  logic          rsp_wrap_s;
  logic          busy_s;

  logic [W-1:0] fi_x = '0;
  logic [W-1:0] fi_y;
  logic         fi_wrap;

  int   nvec = 0;
  int   nfail = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] m_cnt [N] = '{default: '0};
  int           m_ptr = 0;
  logic         m_rsp_vld = 1'b0;
  logic [1:0]   m_rsp_id = '0;
  logic [W-1:0] m_rsp_cnt = '0;
  logic         m_rsp_wrap = 1'b0;

  inc_counter_bank #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .clr_vld(clr_vld), .clr_id(clr_id),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_cnt(rsp_cnt), .rsp_wrap(rsp_wrap), .busy(busy)
  );

  inc_counter_bank #(.N(N), .W(SW)) dut_s (
    .clk(clk), .rst(rst), .req(req_s), .ack(ack_s), .clr_vld(clr_vld_s), .clr_id(clr_id_s),
    .rsp_vld(rsp_vld_s), .rsp_id(rsp_id_s), .rsp_cnt(rsp_cnt_s), .rsp_wrap(rsp_wrap_s), .busy(busy_s)
  );

  fast_inc #(.W(W)) u_fi (.x(fi_x), .y(fi_y), .wrap(fi_wrap));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic cv, input logic [1:0] cid);
    req     = r;
    clr_vld = cv;
    clr_id  = cid;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference arbitration: first eligible requester scanning up from the pointer.
  function automatic int model_grant();
    int g = -1;
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (g < 0 && req[i] && !(clr_vld && clr_id == 2'(i))) g = i;
    end
    return g;
  endfunction

  function automatic logic [N-1:0] model_ack();
    int g = model_grant();
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] <= '0;
      m_ptr      <= 0;
      m_rsp_vld  <= 1'b0;
      m_rsp_id   <= '0;
      m_rsp_cnt  <= '0;
      m_rsp_wrap <= 1'b0;
    end else begin
      if (clr_vld) m_cnt[clr_id] <= '0;
      if (model_grant() >= 0) begin
        m_cnt[model_grant()] <= m_cnt[model_grant()] + 32'd1;
        m_ptr      <= (model_grant() + 1) % N;
        m_rsp_vld  <= 1'b1;
        m_rsp_id   <= 2'(model_grant());
        m_rsp_cnt  <= m_cnt[model_grant()] + 32'd1;
        m_rsp_wrap <= (m_cnt[model_grant()] + 32'd1) == 32'd0;
      end else begin
        m_rsp_vld  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("ack", ack, model_ack());
      checkOutput("ack_onehot", ($countones(ack) <= 1), 1);
      checkOutput("busy", busy, |req);
      checkOutput("rsp_vld", rsp_vld, m_rsp_vld);
      checkOutput("rsp_id", rsp_id, m_rsp_id);
      checkOutput("rsp_cnt", rsp_cnt, m_rsp_cnt);
      checkOutput("rsp_wrap", rsp_wrap, m_rsp_wrap);
      for (int i = 0; i < N; i++)
        checkOutput($sformatf("cnt%0d", i), dut.cnt[i], m_cnt[i]);
    end
  end

  initial begin
    logic [N-1:0] exp_order [8];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state, with requests present to confirm ack stays low.
    req = 4'b1111;
    #3;
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_rsp_vld", rsp_vld, 0);
    checkOutput("reset_rsp_cnt", rsp_cnt, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Single requester held for three cycles.
    doReset();
    for (int k = 1; k <= 3; k++) begin
      req = 4'b0001;
      #1 checkOutput("t1_ack", ack, 4'b0001);
      @(posedge clk);
      #1;
      checkOutput("t1_rsp_vld", rsp_vld, 1);
      checkOutput("t1_rsp_id", rsp_id, 0);
      checkOutput("t1_rsp_cnt", rsp_cnt, k);
    end
    req = '0;

    // All requesters: strict rotation, two increments each.
    doReset();
    for (int k = 0; k < 8; k++) begin
      req = 4'b1111;
      #1 checkOutput("t2_ack_order", ack, exp_order[k]);
      @(posedge clk);
      #1;
    end
    req = '0;
    for (int i = 0; i < N; i++) checkOutput("t2_cnt", dut.cnt[i], 2);

    // Clear masks only its own requester: pointer at 1, counter 1 holds 1.
    doReset();
    applyStimulus(4'b0010, 1'b0, 2'd0);
    applyStimulus(4'b0001, 1'b0, 2'd0);
    req = 4'b0110; clr_vld = 1'b1; clr_id = 2'd1;
    #1 checkOutput("t3_ack", ack, 4'b0100);
    @(posedge clk);
    #1;
    checkOutput("t3_rsp_id", rsp_id, 2);
    checkOutput("t3_rsp_cnt", rsp_cnt, 1);
    checkOutput("t3_cnt1", dut.cnt[1], 0);
    applyStimulus(4'b0000, 1'b0, 2'd0);

    // Random traffic.
    for (int k = 0; k < 10000; k++)
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
    applyStimulus(4'b0000, 1'b0, 2'd0);

    // Reset while a response is live kills it before the next edge.
    applyStimulus(4'b1111, 1'b0, 2'd0);
    checkOutput("t5_rsp_vld_before", rsp_vld, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rsp_vld", rsp_vld, 0);
    checkOutput("t5_rr_ptr", dut.rr_ptr, 0);
    checkOutput("t5_ack", ack, 0);
    for (int i = 0; i < N; i++) checkOutput("t5_cnt", dut.cnt[i], 0);
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Narrow bank: drive counter 2 through its wrap.
    req_s = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      checkOutput("t6_rsp_id", rsp_id_s, 2);
      checkOutput("t6_rsp_cnt", rsp_cnt_s, 64'(k % 16));
      checkOutput("t6_rsp_wrap", rsp_wrap_s, (k == 16));
    end
    req_s = '0;

    // Full-width incrementer boundaries and random values.
    fi_x = 32'hFFFF_FFFE;
    #1 checkOutput("fi_y_fffe", fi_y, 32'hFFFF_FFFF);
    checkOutput("fi_wrap_fffe", fi_wrap, 0);
    fi_x = 32'hFFFF_FFFF;
    #1 checkOutput("fi_y_ffff", fi_y, 0);
    checkOutput("fi_wrap_ffff", fi_wrap, 1);
    fi_x = 32'h0000_0000;
    #1 checkOutput("fi_y_zero", fi_y, 1);
    for (int k = 0; k < 200; k++) begin
      fi_x = $urandom;
      #1;
      checkOutput("fi_y_rand", fi_y, fi_x + 32'd1);
      checkOutput("fi_wrap_rand", fi_wrap, (fi_x == 32'hFFFF_FFFF));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/inc_counter_bank.md
# inc_counter_bank

Bank of N W-bit event counters sharing a single fast-increment datapath (rightmost-zero mask XOR). Requesters compete through a round-robin arbiter: one increment is granted per cycle, the selected counter is updated, and a registered response carries the new value. It sits between event sources and statistics/telemetry logic, wherever several counters would otherwise each need their own adder.

## Interface
- N, 4, number of counters and requesters (2..16)
- W, 32, counter width in bits (>=2)
- clk  in  1  clock, all state rising-edge
- rst  in  1  reset; asynchronous, active-high
- req  in  N  per-requester increment request (level, held until ack)
- ack  out  N  one-hot grant; combinational from req, clr and arbiter state; request consumed on the clk edge where ack[i]=1
- clr_vld  in  1  clear command valid (always accepted, no backpressure)
- clr_id  in  $clog2(N)  counter index to clear
- rsp_vld  out  1  registered; an increment completed last cycle
- rsp_id  out  $clog2(N)  index of the counter incremented
- rsp_cnt  out  W  post-increment counter value
- rsp_wrap  out  1  increment wrapped all-ones -> zero
- busy  out  1  any req bit high (combinational)

## Operation
- State: cnt[N] (W bits each), rr_ptr ($clog2(N) bits, highest-priority index), response registers.
- Eligibility: elig[i] = req[i] & ~(clr_vld & clr_id==i).
- Arbitration: first eligible index at or after rr_ptr, scanning upward modulo N. At most one ack bit per cycle; ack=0 when nothing is eligible.
- Grant to g: cnt[g] <= inc(cnt[g]); rr_ptr <= (g+1) mod N; rsp_vld<=1, rsp_id<=g, rsp_cnt<=inc(cnt[g]), rsp_wrap<=(cnt[g]=={W{1}}).
- No grant: rr_ptr holds; rsp_vld<=0; rsp_id, rsp_cnt and rsp_wrap hold their last values.
- inc(x) = x XOR inclusive_lsb_mask(onehot_rightmost_zero(x)). For x all-ones the one-hot is zero, the mask is all-ones and the result is zero (wrap). Must equal x+1 mod 2^W for every x.
- Clear: on clr_vld, cnt[clr_id] <= 0 at the edge. A clear of counter k masks only requester k; another requester may still be granted in the same cycle.
- Clear never produces a response.
- Wrap: a counter wraps silently to 0. rsp_wrap is the only indication.

## Timing
- Reset (async assert, sync-safe deassert): all cnt=0, rr_ptr=0, rsp_vld=0, rsp_id=0, rsp_cnt=0, rsp_wrap=0. ack=0 while rst is high.
- Grant latency 0 (ack combinational). Response latency 1 cycle after the ack edge.
- Throughput: one increment per cycle. Back-to-back increments of the same counter see the updated value with no hazard, because read happens combinationally from state written at the previous edge.
- A requester held high continuously while others also request is served once every at most N cycles (starvation-free).
- Reset mid-operation: pending reqs are dropped, counts are lost, and any in-flight rsp is killed immediately (rsp_vld falls asynchronously).

## Structure
- Package inc_pkg holds the ffs0/inclusive_mask functions (parameterised by width via a local typedef in the sub-module) and a rr_pick function (vector, pointer) returning a one-hot result.
- Sub-module fast_inc #(W): combinational, input x, outputs y and wrap. Instantiated once, fed by a mux of cnt[g].
- Everything else (arbiter, counter array, response registers) lives in inc_counter_bank itself.

## Test plan
- Reset, then req=4'b0001 held for 3 cycles -> ack[0] on each of the 3 cycles; rsp_cnt 1,2,3 with rsp_id=0, each appearing 1 cycle after its ack.
- req=4'b1111 held for 8 cycles from reset -> ack order 0,1,2,3,0,1,2,3; every counter ends at 2.
- Preload counter 2 to 0xFFFF_FFFE via repeated increments (or force in the bench), then increment twice -> rsp_cnt 0xFFFF_FFFF with rsp_wrap=0, then rsp_cnt 0 with rsp_wrap=1.
- req=4'b0110 with clr_vld=1, clr_id=1 in the same cycle, rr_ptr=1 -> ack=4'b0100; cnt[1]=0; rsp_id=2.
- Random req/clr for 10k cycles against a reference model using +1 arithmetic -> exact match of every rsp and count; never more than one ack bit high.
- Assert rst mid-stream while rsp_vld=1 -> rsp_vld, all counts and rr_ptr read 0 before the next clk edge.
